// File: rtl/seven_seg_driver.sv
// Four-digit multiplexed seven-segment driver with a sequential
// double-dabble binary-to-BCD converter.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seven_seg_driver #(
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] num,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        upd
);

    localparam int unsigned NUM_W = 13;
    localparam int unsigned BCD_W = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_W-1:0]        shift_q, shift_d;
    logic [BCD_W-1:0]        scratch_q, scratch_d;
    logic [BCD_W-1:0]        disp_q, disp_d;
    logic                    upd_q, upd_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [BCD_W-1:0]        adj;

    logic [1:0] sel;
    logic [3:0] digit;
    logic       blank;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            disp_q    <= '0;
            upd_q     <= 1'b0;
            refresh_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            disp_q    <= disp_d;
            upd_q     <= upd_d;
            refresh_q <= refresh_d;
        end
    end

    // Conversion FSM: capture, 13 add-3/shift steps, then publish to display
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        disp_d    = disp_q;
        upd_d     = 1'b0;
        adj       = scratch_q;
        refresh_d = refresh_q + REFRESH_BITS'(1);

        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                shift_d   = num;
                scratch_d = '0;
                cnt_d     = CNT_W'(NUM_W);
                state_d   = SHIFT;
            end
            SHIFT: begin
                {scratch_d, shift_d} = {adj[BCD_W-2:0], shift_q, 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_d  = scratch_q;
                upd_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign upd = upd_q;

    // Digit scan: top two refresh bits pick the active digit
    always_comb begin
        sel   = refresh_q[REFRESH_BITS-1 -: 2];
        anode = 4'b1110;
        digit = disp_q[3:0];
        blank = 1'b0;
        case (sel)
            2'd0: begin anode = 4'b1110; digit = disp_q[3:0];   end
            2'd1: begin anode = 4'b1101; digit = disp_q[7:4];   end
            2'd2: begin anode = 4'b1011; digit = disp_q[11:8];  end
            default: begin anode = 4'b0111; digit = disp_q[15:12]; end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every higher digit are zero
        case (sel)
            2'd1:    blank = (disp_q[15:4]  == 12'd0);
            2'd2:    blank = (disp_q[15:8]  == 8'd0);
            2'd3:    blank = (disp_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    // Segment decode, active-low {a,b,c,d,e,f,g}
    always_comb begin
        cathode = 7'b1111111;
        if (!blank) begin
            case (digit)
                4'd0:    cathode = 7'b0000001;
                4'd1:    cathode = 7'b1001111;
                4'd2:    cathode = 7'b0010010;
                4'd3:    cathode = 7'b0000110;
                4'd4:    cathode = 7'b1001100;
                4'd5:    cathode = 7'b0100100;
                4'd6:    cathode = 7'b0100000;
                4'd7:    cathode = 7'b0001111;
                4'd8:    cathode = 7'b0000000;
                4'd9:    cathode = 7'b0000100;
                default: cathode = 7'b1111111;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_driver.sv
// Directed testbench for seven_seg_driver with a 4-bit refresh counter.
module tb_seven_seg_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] num;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        upd;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;   // refresh counter model: cycles since reset release
    int k_wait   = 0;

    seven_seg_driver #(.REFRESH_BITS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .num     (num),
        .anode   (anode),
        .cathode (cathode),
        .upd     (upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] exp_anode(input int c);
        logic [3:0] a;
        a = 4'b1111;
        a[(c >> 2) & 3] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] exp_cath(input int v, input int c);
        int s;
        int d [4];
        bit blank;
        s = (c >> 2) & 3;
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = (v / 100) % 10;
        d[3] = (v / 1000) % 10;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (s == 3) blank = (d[3] == 0);
        if (s == 2) blank = (d[3] == 0) && (d[2] == 0);
        if (s == 1) blank = (d[3] == 0) && (d[2] == 0) && (d[1] == 0);
`endif
        return blank ? 7'b1111111 : seg_of(d[s]);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (rst) cyc++;
    endtask

    // Wait for the next upd pulse; k_wait returns the number of cycles taken
    task automatic wait_upd(input int budget);
        k_wait = 0;
        do begin
            tick();
            k_wait++;
        end while (upd !== 1'b1 && k_wait < budget);
        check("upd_seen", 16'(upd), 16'd1);
    endtask

    // Sample n consecutive cycles starting at an upd pulse and check the scan
    task automatic check_scan(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            check("anode",   16'(anode),   16'(exp_anode(cyc)));
            check("cathode", 16'(cathode), 16'(exp_cath(v, cyc)));
            check("onehot",  16'($countones(~anode)), 16'd1);
            check("upd_pulse", 16'(upd), 16'(i == 0));
            if (i < n - 1) tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        num = 13'd0;
        repeat (3) tick();
        check("rst_anode",   16'(anode),   16'(4'b1110));
        check("rst_cathode", 16'(cathode), 16'(7'b0000001));
        check("rst_upd",     16'(upd),     16'd0);

        // Release with num=0: first upd after 15 edges, full anode sweep
        rst = 1'b1;
        cyc = 0;
        check("rel_anode", 16'(anode), 16'(4'b1110));
        for (int n = 1; n <= 16; n++) begin
            tick();
            check("first_upd", 16'(upd),     16'(n == 15));
            check("sweep_an",  16'(anode),   16'(exp_anode(cyc)));
            check("sweep_cat", 16'(cathode), 16'(exp_cath(0, cyc)));
        end

        // Maximum value, and steady-state upd period
        num = 13'd8191;
        wait_upd(20);
        wait_upd(20);
        check("upd_period", 16'(k_wait), 16'd15);
        check_scan(8191, 15);

        // Change num on the 3rd SHIFT cycle: in-flight conversion unaffected
        wait_upd(20);
        num = 13'd1234;
        tick();          // IDLE captures 1234
        tick();
        tick();          // now in the 3rd SHIFT cycle
        num = 13'd4321;
        wait_upd(20);
        check_scan(1234, 15);
        wait_upd(20);
        check_scan(4321, 15);

        // Reset on the 7th SHIFT cycle aborts the conversion
        wait_upd(20);
        num = 13'd555;
        tick();          // capture
        repeat (6) tick();
        rst = 1'b0;
        cyc = 0;
        #1;
        check("abort_anode",   16'(anode),   16'(4'b1110));
        check("abort_cathode", 16'(cathode), 16'(7'b0000001));
        check("abort_upd",     16'(upd),     16'd0);
        repeat (3) begin
            tick();
            check("hold_upd",     16'(upd),     16'd0);
            check("hold_cathode", 16'(cathode), 16'(7'b0000001));
        end
        #4;
        rst = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            check("re_upd", 16'(upd), 16'(n == 15));
            check("re_cat", 16'(cathode), 16'(exp_cath((n >= 15) ? 555 : 0, cyc)));
        end

        // Single-digit value exercises leading-zero handling
        num = 13'd7;
        wait_upd(20);
        wait_upd(20);
        check_scan(7, 15);

        // Counter wrap: 2^4 + 5 cycles
        for (int i = 0; i < 21; i++) begin
            tick();
            check("wrap_an", 16'(anode), 16'(exp_anode(cyc)));
            check("wrap_1h", 16'($countones(~anode)), 16'd1);
            if ((cyc % 16) == 0) check("wrap_zero", 16'(anode), 16'(4'b1110));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
